// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one imem read at a time and pushes {pc, inst}
// into the instruction queue, with a one-entry skid buffer for queue back-pressure.
module fetch_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            request_new_inst,
  output logic [XLEN-1:0] imem_addr,
  output logic [3:0]      imem_rmask,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_resp,
  input  logic            iq_full,
  output logic            iq_push,
  output logic [XLEN-1:0] iq_pc,
  output logic [31:0]     iq_inst
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [XLEN-1:0] req_pc;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_inst;
  logic            req_issue;
  logic            buf_set;
  logic            buf_clr;

  // Outputs are gated by rst so that the reset cycle itself presents all zeros.
  always_comb begin
    state_next       = state;
    req_issue        = 1'b0;
    buf_set          = 1'b0;
    buf_clr          = 1'b0;
    request_new_inst = 1'b0;
    imem_addr        = '0;
    imem_rmask       = 4'h0;
    iq_push          = 1'b0;
    iq_pc            = '0;
    iq_inst          = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (redirect) begin
            buf_clr = 1'b1;
          end else if (buf_valid) begin
            if (!iq_full) begin
              iq_push = 1'b1;
              iq_pc   = buf_pc;
              iq_inst = buf_inst;
              buf_clr = 1'b1;
            end
          end else begin
            req_issue  = 1'b1;
            imem_rmask = 4'hF;
            imem_addr  = {pc[XLEN-1:2], 2'b00};
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            state_next = IDLE;
            if (!redirect) begin
              request_new_inst = 1'b1;
              if (!iq_full) begin
                iq_push = 1'b1;
                iq_pc   = req_pc;
                iq_inst = imem_rdata;
              end else begin
                buf_set = 1'b1;
              end
            end
          end else if (redirect) begin
            state_next = DISCARD;
          end
        end
        DISCARD: begin
          if (imem_resp) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_pc    <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else begin
      state <= state_next;
      if (req_issue) req_pc <= pc;
      if (buf_set) begin
        buf_valid <= 1'b1;
        buf_pc    <= req_pc;
        buf_inst  <= imem_rdata;
      end else if (buf_clr) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: one linear stimulus sequence, cycle-by-cycle expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        request_new_inst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        iq_full;
  logic        iq_push;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .redirect         (redirect),
    .request_new_inst (request_new_inst),
    .imem_addr        (imem_addr),
    .imem_rmask       (imem_rmask),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .iq_full          (iq_full),
    .iq_push          (iq_push),
    .iq_pc            (iq_pc),
    .iq_inst          (iq_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change at the negedge; outputs are sampled 1ns later, well away from posedge.
  task automatic drive(input logic r, input logic [31:0] p, input logic rd,
                       input logic resp, input logic [31:0] rdata, input logic full);
    @(negedge clk);
    rst        = r;
    pc         = p;
    redirect   = rd;
    imem_resp  = resp;
    imem_rdata = rdata;
    iq_full    = full;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] rmask, input logic [31:0] addr,
                            input logic push, input logic [31:0] ipc, input logic [31:0] iinst,
                            input logic rni);
    chk({tag, ".rmask"}, {28'd0, imem_rmask}, {28'd0, rmask});
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".push"},  {31'd0, iq_push}, {31'd0, push});
    chk({tag, ".iq_pc"}, iq_pc, ipc);
    chk({tag, ".iq_inst"}, iq_inst, iinst);
    chk({tag, ".rni"},   {31'd0, request_new_inst}, {31'd0, rni});
  endtask

  initial begin
    rst = 1'b1; pc = '0; redirect = 1'b0; imem_resp = 1'b0; imem_rdata = '0; iq_full = 1'b0;

    // Reset
    drive(1, 32'h6000_0000, 0, 0, 32'h0, 0); expect_out("rst0", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(1, 32'h6000_0000, 0, 1, 32'hFFFF_FFFF, 0); expect_out("rst1", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);

    // 1: basic fetch, latency 1
    drive(0, 32'h6000_0000, 0, 0, 32'h0, 0);
    expect_out("t1_req", 4'hF, 32'h6000_0000, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0000, 0, 1, 32'h0000_0013, 0);
    expect_out("t1_resp", 4'h0, 32'h0, 1, 32'h6000_0000, 32'h0000_0013, 1);
    drive(0, 32'h6000_0004, 0, 0, 32'h0, 0);
    expect_out("t1_req2", 4'hF, 32'h6000_0004, 0, 32'h0, 32'h0, 0);

    // 2: queue full on response, held for 3 cycles
    drive(0, 32'h6000_0004, 0, 1, 32'h0010_0093, 1);
    expect_out("t2_buf", 4'h0, 32'h0, 0, 32'h0, 32'h0, 1);
    drive(0, 32'h6000_0008, 0, 0, 32'h0, 1);
    expect_out("t2_hold1", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0008, 0, 0, 32'h0, 1);
    expect_out("t2_hold2", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0008, 0, 0, 32'h0, 0);
    expect_out("t2_drain", 4'h0, 32'h0, 1, 32'h6000_0004, 32'h0010_0093, 0);
    drive(0, 32'h6000_0008, 0, 0, 32'h0, 0);
    expect_out("t2_req", 4'hF, 32'h6000_0008, 0, 32'h0, 32'h0, 0);

    // 3: redirect one cycle after request, latency 4
    drive(0, 32'h6000_0008, 1, 0, 32'h0, 0);
    expect_out("t3_redir", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0100, 0, 0, 32'h0, 0);
    expect_out("t3_disc1", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0100, 0, 0, 32'h0, 0);
    expect_out("t3_disc2", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0100, 0, 1, 32'hDEAD_BEEF, 0);
    expect_out("t3_drop", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0100, 0, 0, 32'h0, 0);
    expect_out("t3_req", 4'hF, 32'h6000_0100, 0, 32'h0, 32'h0, 0);

    // 4: redirect coincident with response
    drive(0, 32'h6000_0100, 1, 1, 32'h1111_1111, 0);
    expect_out("t4_drop", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0200, 0, 0, 32'h0, 0);
    expect_out("t4_req", 4'hF, 32'h6000_0200, 0, 32'h0, 32'h0, 0);

    // 5: redirect while the skid buffer holds an entry and the queue is full
    drive(0, 32'h6000_0200, 0, 1, 32'h2222_2222, 1);
    expect_out("t5_buf", 4'h0, 32'h0, 0, 32'h0, 32'h0, 1);
    drive(0, 32'h6000_0204, 0, 0, 32'h0, 1);
    expect_out("t5_hold", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0204, 1, 0, 32'h0, 1);
    expect_out("t5_redir", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0300, 0, 0, 32'h0, 0);
    expect_out("t5_req", 4'hF, 32'h6000_0300, 0, 32'h0, 32'h0, 0);

    // 6: reset while in WAIT, then a late response
    drive(1, 32'h6000_0300, 0, 0, 32'h0, 0);
    expect_out("t6_rst", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0300, 0, 1, 32'h3333_3333, 0);
    expect_out("t6_late", 4'hF, 32'h6000_0300, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0300, 0, 0, 32'h0, 0);
    expect_out("t6_wait", 4'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h6000_0300, 0, 1, 32'h0000_0044, 0);
    expect_out("t6_resp", 4'h0, 32'h0, 1, 32'h6000_0300, 32'h0000_0044, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer side of the PC register's fetch interface.
- Takes the current `pc`, issues one instruction-memory read at a time, and pushes `{pc, instruction}` into the instruction queue.
- Pulses `request_new_inst` to advance the PC once an instruction is captured.
- Discards in-flight or buffered fetches on any front-end redirect: flush, branch, jump, jalr, or hardware-scheduler swap.

Parameters:
- XLEN, 32, width of PC, address and instruction words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc  in  XLEN  current fetch PC from the PC register.
- redirect  in  1  OR of `flush | br_en | jump_en | jalr_done | hardware_scheduler_swap_pc`; the PC changes next cycle.
- request_new_inst  out  1  one-cycle pulse: instruction at `pc` captured, PC register advances.
- imem_addr  out  XLEN  read address, `{pc[XLEN-1:2], 2'b00}`.
- imem_rmask  out  4  `4'hF` for exactly one cycle per request, else `4'h0`.
- imem_rdata  in  32  instruction data, valid when `imem_resp`.
- imem_resp  in  1  one-cycle response strobe; latency ≥1 cycle after the request cycle.
- iq_full  in  1  instruction queue cannot accept a push this cycle.
- iq_push  out  1  push `iq_pc`/`iq_inst` this cycle.
- iq_pc  out  XLEN  PC of the pushed instruction.
- iq_inst  out  32  pushed instruction word.

Behaviour:
- Reset:
  - State IDLE; `buf_valid=0`; `req_pc=0`.
  - All outputs low/zero: `request_new_inst`, `imem_rmask`, `imem_addr`, `iq_push`, `iq_pc`, `iq_inst`.
  - Reset mid-request abandons the request; a `imem_resp` in the cycle after reset deasserts, while in IDLE, is ignored.
- State machine: IDLE, WAIT, DISCARD. At most one outstanding imem request.
- IDLE:
  - If `buf_valid` and `!iq_full` and `!redirect`: `iq_push=1` with the buffered pc/inst; clear `buf_valid`; no request this cycle.
  - Else if `!buf_valid` and `!redirect`: drive `imem_addr` from `pc` and `imem_rmask=4'hF` (combinational, this cycle only); latch `req_pc<=pc`; go to WAIT.
  - If `redirect=1`: no request, clear `buf_valid`, stay IDLE.
- WAIT:
  - `imem_resp & redirect`: drop data, `request_new_inst=0`, go to IDLE.
  - `imem_resp & !redirect & !iq_full`: `iq_push=1`, `iq_pc=req_pc`, `iq_inst=imem_rdata`, `request_new_inst=1`, go to IDLE.
  - `imem_resp & !redirect & iq_full`: store into the 1-entry skid buffer (`buf_valid<=1`), `request_new_inst=1`, go to IDLE.
  - `!imem_resp & redirect`: go to DISCARD.
  - Otherwise hold.
- DISCARD:
  - On `imem_resp`: drop data, go to IDLE; `redirect` this cycle has no further effect.
  - Never pushes, never pulses `request_new_inst`.
- Invariants:
  - `request_new_inst` is never 1 when `redirect` is 1 in the same cycle.
  - `request_new_inst` pulses exactly once per captured instruction.
  - `iq_push` only when `!iq_full`.
  - `iq_pc` always equals the PC presented when the request was issued.
- Throughput:
  - With a 1-cycle-latency memory and no stalls: one instruction per 2 cycles (request, response).
  - The first request issues in the first cycle after `rst` deasserts.
- Redirect timing: the new PC is sampled and requested the cycle after `redirect`, when the FSM is in IDLE.

Test Plan:
1. Reset release, `pc=0x6000_0000`, mem latency 1, `iq_full=0`:
   - Cycle 1: `imem_rmask=F`, `imem_addr=0x6000_0000`.
   - Cycle 2: resp `0x00000013` → `iq_push=1`, `iq_pc=0x6000_0000`, `request_new_inst=1`.
   - Next request at `0x6000_0004`.
2. Queue full on response, `iq_full=1` for 3 cycles:
   - Response is buffered and `request_new_inst` pulses once.
   - No new `imem_rmask` while the buffer is full.
   - Push occurs in the cycle `iq_full` drops, then the next request follows.
3. Redirect 1 cycle after a request, mem latency 4:
   - FSM enters DISCARD; the response is dropped with no push and no `request_new_inst`.
   - Next request uses the redirected pc (e.g. `0x6000_0100`).
4. Redirect coincident with `imem_resp` → data dropped, `request_new_inst=0`; next cycle requests the new pc.
5. Redirect while the buffer holds an entry and `iq_full=1` → buffer cleared, no push ever occurs for that entry.
6. `rst` asserted while in WAIT → all outputs zero next cycle, and a late `imem_resp` produces no push.
